// File: rtl/axi4s_fill_header_if.sv
// AXI4-Stream bundle shared by the packet-processing blocks.
// tuser carries {error, trailing bytes}; a trailing-byte count of 0 means a full word.
interface AxiStreamIf #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 4
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/axi4s_fill_header.sv
// Overwrites the leading bytes of each AXI4-Stream packet with a header taken
// from a side channel (one header per packet); all other bytes pass through.
module axi4s_fill_header #(
    parameter int HDR_START = 0,
    parameter int HDR_BYTES = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    AxiStreamIf.slave              i,
    AxiStreamIf.master             o,
    input  logic [HDR_BYTES*8-1:0] hdr_tdata,
    input  logic                   hdr_tvalid,
    output logic                   hdr_tready
);
    localparam int DATA_WIDTH    = $bits(i.tdata);
    localparam int USER_WIDTH    = $bits(i.tuser);
    localparam int BPW           = DATA_WIDTH / 8;
    localparam int UWIDTH        = $clog2(BPW + 1);
    localparam int HDR_END       = HDR_START + HDR_BYTES;
    localparam int LAST_HDR_WORD = (HDR_END - 1) / BPW;
    localparam int WCNT_W        = $clog2(LAST_HDR_WORD + 2);
    localparam int LAST_BYTES    = HDR_END - LAST_HDR_WORD * BPW;

    localparam logic [1:0] ST_WAIT_HDR = 2'd0;
    localparam logic [1:0] ST_HDR      = 2'd1;
    localparam logic [1:0] ST_PASS     = 2'd2;

    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(LAST_HDR_WORD);
    localparam logic [WCNT_W-1:0] WCNT_SAT  = WCNT_W'(LAST_HDR_WORD + 1);

    if (HDR_START != 0) begin : g_bad_start
        $fatal(1, "axi4s_fill_header: HDR_START must be 0");
    end
    if (HDR_BYTES < 1 || HDR_BYTES > 64) begin : g_bad_bytes
        $fatal(1, "axi4s_fill_header: HDR_BYTES must be 1..64");
    end
    if ($bits(o.tdata) != DATA_WIDTH || $bits(o.tuser) != USER_WIDTH) begin : g_bad_match
        $fatal(1, "axi4s_fill_header: input and output stream widths differ");
    end
    if (USER_WIDTH != UWIDTH + 1) begin : g_bad_user
        $fatal(1, "axi4s_fill_header: tuser must be {error, trailing bytes}");
    end

    logic [1:0]            state_reg, state_next;
    logic [WCNT_W-1:0]     wcnt_reg, wcnt_next;
    logic                  tvalid_reg, tlast_reg;
    logic [DATA_WIDTH-1:0] tdata_reg, data_next;
    logic [USER_WIDTH-1:0] tuser_reg, user_next;
    logic                  i_tready, accept, at_last_hdr_word, short_pkt;
    logic [UWIDTH-1:0]     in_bytes, valid_bytes;

    assign i_tready   = (!tvalid_reg || o.tready) && (state_reg != ST_WAIT_HDR || hdr_tvalid);
    assign i.tready   = i_tready;
    assign accept     = i.tvalid && i_tready;
    assign at_last_hdr_word = (wcnt_reg == WCNT_LAST);
    assign hdr_tready = accept && hdr_tvalid && (state_reg != ST_PASS)
                        && (i.tlast || at_last_hdr_word);

    // A packet is short when it ends before the last header byte position.
    assign in_bytes    = i.tuser[UWIDTH-1:0];
    assign valid_bytes = (in_bytes == '0) ? UWIDTH'(BPW) : in_bytes;
    assign short_pkt   = i.tlast && ((wcnt_reg < WCNT_LAST) ||
                         (at_last_hdr_word && valid_bytes < UWIDTH'(LAST_BYTES)));
    assign user_next   = {i.tuser[USER_WIDTH-1] | short_pkt, in_bytes};

    // Per output byte: pick the header byte that maps onto it for the current word index.
    for (genvar gi = 0; gi < BPW; gi++) begin : g_byte
        logic [LAST_HDR_WORD:0]      hit;
        logic [LAST_HDR_WORD:0][7:0] val;
        logic [7:0]                  byte_out;
        for (genvar gw = 0; gw <= LAST_HDR_WORD; gw++) begin : g_word
            localparam int P = gw * BPW + gi;
            if (P >= HDR_START && P < HDR_END) begin : g_hdr
                assign hit[gw] = (wcnt_reg == WCNT_W'(gw));
                assign val[gw] = hdr_tdata[8*(P-HDR_START) +: 8];
            end else begin : g_data
                assign hit[gw] = 1'b0;
                assign val[gw] = 8'h00;
            end
        end
        always_comb begin
            byte_out = i.tdata[8*gi +: 8];
            for (int w = 0; w <= LAST_HDR_WORD; w++) begin
                if (hit[w]) byte_out = val[w];
            end
        end
        assign data_next[8*gi +: 8] = byte_out;
    end

    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        if (accept) begin
            if (i.tlast)
                wcnt_next = '0;
            else if (wcnt_reg != WCNT_SAT)
                wcnt_next = wcnt_reg + 1'b1;
            case (state_reg)
                ST_WAIT_HDR, ST_HDR: begin
                    if (i.tlast)
                        state_next = ST_WAIT_HDR;
                    else if (at_last_hdr_word)
                        state_next = ST_PASS;
                    else
                        state_next = ST_HDR;
                end
                default: begin
                    if (i.tlast) state_next = ST_WAIT_HDR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_WAIT_HDR;
            wcnt_reg   <= '0;
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
            tdata_reg  <= '0;
            tuser_reg  <= '0;
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
            if (accept) begin
                tvalid_reg <= 1'b1;
                tdata_reg  <= data_next;
                tuser_reg  <= user_next;
                tlast_reg  <= i.tlast;
            end else if (o.tready) begin
                tvalid_reg <= 1'b0;
            end
        end
    end

    assign o.tvalid = tvalid_reg;
    assign o.tdata  = tdata_reg;
    assign o.tuser  = tuser_reg;
    assign o.tlast  = tlast_reg;
endmodule
